layer_scheduler: RTL

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/layer_pkg.sv | 30 +++
 rtl/layer_mac_lanes.sv | 61 ++++++
 rtl/layer_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
// Shared types and sizing helpers for the layer scheduler and its MAC datapath.
// Contents:
//   state_t      - scheduler FSM states
//   DRAIN_CYCLES - cycles spent flushing the MAC pipeline after the last read
//   chunks_of()  - number of LANES-wide chunks in one neuron's input vector
//   addr_w()     - address width for a memory of a given depth (never below 1)
package layer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    BIAS   = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 2;

  // Number of chunks (CHUNKS) read per neuron.
  function automatic int unsigned chunks_of(input int unsigned num_inputs,
                                            input int unsigned lanes);
    return num_inputs / lanes;
  endfunction

  // clog2 of the depth, kept at least 1 so ports never collapse to zero width.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_mac_lanes.sv
// LANES-wide unsigned multiply, registered adder tree and wrapping accumulator.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - clear the accumulator at the next edge
//   rd_en     - read strobe issued this cycle; its data arrives next cycle
//   in_data   - input chunk, lane i at [i*W +: W]
//   w_data    - weight chunk, same packing
//   acc       - running accumulator (BIAS_WIDTH, two's-complement wrap)
module layer_mac_lanes
  import layer_pkg::*;
#(
  parameter int unsigned WEIGHTS_WIDTH = 8,
  parameter int unsigned BIAS_WIDTH    = 32,
  parameter int unsigned LANES         = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           rd_en,
  input  logic [LANES*WEIGHTS_WIDTH-1:0] in_data,
  input  logic [LANES*WEIGHTS_WIDTH-1:0] w_data,
  output logic [BIAS_WIDTH-1:0]          acc
);

  localparam int unsigned PW = 2 * WEIGHTS_WIDTH;

  logic                  dat_vld;
  logic                  tree_vld;
  logic [BIAS_WIDTH-1:0] tree_sum;
  logic [BIAS_WIDTH-1:0] tree_sum_c;

  // Unsigned lane products, zero-extended, summed across lanes.
  always_comb begin
    tree_sum_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      tree_sum_c = tree_sum_c + BIAS_WIDTH'(
        PW'(in_data[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]) *
        PW'(w_data[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]));
    end
  end

  // dat_vld marks the cycle the memory data is on the bus; tree_vld the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_vld  <= 1'b0;
      tree_vld <= 1'b0;
      tree_sum <= '0;
      acc      <= '0;
    end else begin
      dat_vld  <= rd_en;
      tree_vld <= dat_vld;
      tree_sum <= tree_sum_c;
      if (clr) begin
        acc <= '0;
      end else if (tree_vld) begin
        acc <= acc + tree_sum;
      end
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one fully-connected layer: streams input/weight chunks through the
// MAC lanes, adds the bias, applies optional ReLU and hands each neuron result
// downstream with a valid/ready handshake.
// Ports:
//   CLK, RESET            - clock, asynchronous active-high reset
//   START                 - begin a layer (honoured only when idle)
//   RD_EN                 - memory read strobe (1-cycle read latency)
//   IN_ADDR/W_ADDR        - input and weight chunk addresses
//   BIAS_ADDR             - bias address (current neuron)
//   IN_DATA/W_DATA        - chunk data, lane i at [i*W +: W]
//   BIAS_DATA             - signed bias
//   OUT_VALID/OUT_READY   - result handshake
//   OUT_DATA/OUT_INDEX    - neuron result and its neuron number
//   BUSY                  - high whenever not idle
//   DONE                  - one-cycle pulse after the last result is accepted
module layer_scheduler
  import layer_pkg::*;
#(
  parameter int unsigned WEIGHTS_WIDTH = 8,
  parameter int unsigned BIAS_WIDTH    = 32,
  parameter int unsigned LANES         = 4,
  parameter int unsigned NUM_INPUTS    = 784,
  parameter int unsigned NUM_NEURONS   = 32,
  parameter int unsigned RELU          = 1
) (
  input  logic                                            CLK,
  input  logic                                            RESET,
  input  logic                                            START,
  output logic                                            RD_EN,
  output logic [addr_w(NUM_INPUTS/LANES)-1:0]             IN_ADDR,
  output logic [addr_w(NUM_NEURONS*NUM_INPUTS/LANES)-1:0] W_ADDR,
  output logic [addr_w(NUM_NEURONS)-1:0]                  BIAS_ADDR,
  input  logic [LANES*WEIGHTS_WIDTH-1:0]                  IN_DATA,
  input  logic [LANES*WEIGHTS_WIDTH-1:0]                  W_DATA,
  input  logic [BIAS_WIDTH-1:0]                           BIAS_DATA,
  output logic                                            OUT_VALID,
  input  logic                                            OUT_READY,
  output logic [BIAS_WIDTH-1:0]                           OUT_DATA,
  output logic [addr_w(NUM_NEURONS)-1:0]                  OUT_INDEX,
  output logic                                            BUSY,
  output logic                                            DONE
);

  localparam int unsigned CHUNKS = chunks_of(NUM_INPUTS, LANES);
  localparam int unsigned IAW    = addr_w(CHUNKS);
  localparam int unsigned WAW    = addr_w(NUM_NEURONS * CHUNKS);
  localparam int unsigned NW     = addr_w(NUM_NEURONS);

  localparam logic [IAW-1:0] LAST_CHUNK  = IAW'(CHUNKS - 1);
  localparam logic [NW-1:0]  LAST_NEURON = NW'(NUM_NEURONS - 1);

  if (NUM_INPUTS % LANES != 0) begin : g_bad_lanes
    $error("layer_scheduler: NUM_INPUTS must be a multiple of LANES");
  end

  state_t                state;
  logic [NW-1:0]         neuron;
  logic                  drain_cnt;
  logic                  first_q;
  logic [BIAS_WIDTH-1:0] bias_q;
  logic [BIAS_WIDTH-1:0] acc;
  logic [BIAS_WIDTH-1:0] biased_c;
  logic [BIAS_WIDTH-1:0] result_c;
  logic                  acc_clr_c;

  assign BIAS_ADDR = neuron;

  // Accumulator restarts on every layer start and every accepted result.
  assign acc_clr_c = ((state == IDLE) && START) || ((state == OUTPUT) && OUT_READY);

  assign biased_c = acc + bias_q;
  assign result_c = ((RELU != 0) && biased_c[BIAS_WIDTH-1]) ? '0 : biased_c;

  layer_mac_lanes #(
    .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
    .BIAS_WIDTH    (BIAS_WIDTH),
    .LANES         (LANES)
  ) u_mac (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (acc_clr_c),
    .rd_en   (RD_EN),
    .in_data (IN_DATA),
    .w_data  (W_DATA),
    .acc     (acc)
  );

  // The bias read goes out with the first chunk; its data lands one cycle later.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      first_q <= 1'b0;
      bias_q  <= '0;
    end else begin
      first_q <= (state == RUN) && (IN_ADDR == '0);
      if (first_q) begin
        bias_q <= BIAS_DATA;
      end
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      neuron    <= '0;
      drain_cnt <= 1'b0;
      RD_EN     <= 1'b0;
      IN_ADDR   <= '0;
      W_ADDR    <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_INDEX <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            neuron  <= '0;
            IN_ADDR <= '0;
            W_ADDR  <= '0;
            RD_EN   <= 1'b1;
            BUSY    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (IN_ADDR == LAST_CHUNK) begin
            RD_EN     <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            IN_ADDR <= IN_ADDR + IAW'(1);
            W_ADDR  <= W_ADDR + WAW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
            state <= BIAS;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        BIAS: begin
          OUT_DATA  <= result_c;
          OUT_INDEX <= neuron;
          OUT_VALID <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (neuron == LAST_NEURON) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              // Weight chunks of consecutive neurons are contiguous.
              neuron  <= neuron + NW'(1);
              IN_ADDR <= '0;
              W_ADDR  <= W_ADDR + WAW'(1);
              RD_EN   <= 1'b1;
              state   <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
